// File: rtl/turtle_loader_pkg.sv
// Shared definitions for the turtle program loader: frame sync byte,
// loader state encoding and a small helper to classify states.
package turtle_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAY_HI,
    ST_PAY_LO,
    ST_CHECKSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  // A frame is in progress in every state except the resting ones.
  function automatic logic state_is_busy(input loader_state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream input and instruction memory write port of the program loader.
// The master side feeds bytes and observes the memory writes; the slave side
// is the loader itself.
interface program_loader_if #(
  parameter int BYTE_W   = 8,
  parameter int I_ADDR_W = 12,
  parameter int INST_W   = 16
);

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                imem_we;
  logic [I_ADDR_W-1:0] imem_waddr;
  logic [INST_W-1:0]   imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: parses a framed byte stream (sync, 16-bit word count,
// payload, 8-bit additive checksum), writes each instruction word into the
// instruction memory and holds the CPU core in reset until a frame with a
// matching checksum has been fully loaded.
module program_loader
  import turtle_loader_pkg::*;
#(
  parameter int INST_W         = 16,
  parameter int I_ADDR_W       = 12,
  parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W,
  parameter int BYTE_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  program_loader_if.slave         bus,
  input  logic                    reload,
  output logic                    core_reset_n,
  output logic                    busy,
  output logic                    done,
  output logic                    load_error
);

  localparam logic [I_ADDR_W:0] CNT_ONE = {{I_ADDR_W{1'b0}}, 1'b1};

  loader_state_e       state;
  loader_state_e       state_next;

  logic [BYTE_W-1:0]   len_hi_q;
  logic [2*BYTE_W-1:0] n_words_q;
  logic [BYTE_W-1:0]   hi_byte_q;
  logic [BYTE_W-1:0]   checksum_q;
  // One bit wider than the address so a full-depth load never wraps.
  logic [I_ADDR_W:0]   word_cnt_q;

  logic                imem_we_q;
  logic [I_ADDR_W-1:0] imem_waddr_q;
  logic [INST_W-1:0]   imem_wdata_q;
  logic                load_error_q;

  logic                accept;
  logic                is_sync;
  logic [2*BYTE_W-1:0] len_word;
  logic                len_ok;
  logic [I_ADDR_W:0]   word_cnt_inc;
  logic                last_word;
  logic [BYTE_W-1:0]   sum_next;
  logic                word_done;

  assign accept       = bus.in_valid && bus.in_ready;
  assign is_sync      = (bus.in_data == BYTE_W'(SYNC_BYTE));
  assign len_word     = {len_hi_q, bus.in_data};
  assign len_ok       = (len_word != '0) && (32'(len_word) <= 32'(I_MEMORY_DEPTH));
  assign word_cnt_inc = word_cnt_q + CNT_ONE;
  assign last_word    = (32'(word_cnt_inc) == 32'(n_words_q));
  assign sum_next     = checksum_q + bus.in_data;
  assign word_done    = (state == ST_PAY_LO) && accept && !reload;

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign load_error     = load_error_q;

  // State register; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived outputs; reload overrides everything.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b1;
    busy         = state_is_busy(state);
    done         = 1'b0;
    core_reset_n = 1'b0;

    if (state == ST_DONE || state == ST_ERROR) begin
      bus.in_ready = 1'b0;
    end
    if (state == ST_DONE) begin
      done         = 1'b1;
      core_reset_n = 1'b1;
    end

    if (reload) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (accept && is_sync) state_next = ST_LEN_HI;
        ST_LEN_HI:   if (accept) state_next = ST_LEN_LO;
        ST_LEN_LO:   if (accept) state_next = len_ok ? ST_PAY_HI : ST_ERROR;
        ST_PAY_HI:   if (accept) state_next = ST_PAY_LO;
        ST_PAY_LO:   if (accept) state_next = last_word ? ST_CHECKSUM : ST_PAY_HI;
        ST_CHECKSUM: if (accept) state_next = (bus.in_data == checksum_q) ? ST_DONE : ST_ERROR;
        ST_DONE:     state_next = ST_DONE;
        ST_ERROR:    state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: length capture, word assembly, memory write and checksum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_hi_q     <= '0;
      n_words_q    <= '0;
      hi_byte_q    <= '0;
      checksum_q   <= '0;
      word_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= word_done;
      if (!reload) begin
        case (state)
          ST_IDLE: begin
            if (accept && is_sync) begin
              checksum_q   <= '0;
              word_cnt_q   <= '0;
              load_error_q <= 1'b0;
            end
          end
          ST_LEN_HI: begin
            if (accept) len_hi_q <= bus.in_data;
          end
          ST_LEN_LO: begin
            if (accept) n_words_q <= len_word;
          end
          ST_PAY_HI: begin
            if (accept) begin
              hi_byte_q  <= bus.in_data;
              checksum_q <= sum_next;
            end
          end
          ST_PAY_LO: begin
            if (accept) begin
              imem_waddr_q <= word_cnt_q[I_ADDR_W-1:0];
              imem_wdata_q <= {hi_byte_q, bus.in_data};
              checksum_q   <= sum_next;
              word_cnt_q   <= word_cnt_inc;
            end
          end
          default: ;
        endcase
        if (state != ST_ERROR && state_next == ST_ERROR) begin
          load_error_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: feeds hand-built frames and checks
// status outputs and captured instruction memory writes against expected
// values worked out by hand.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic reload;
  logic core_reset_n;
  logic busy;
  logic done;
  logic load_error;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [7:0]  frame[$];

  program_loader_if #(.BYTE_W(8), .I_ADDR_W(12), .INST_W(16)) bus();

  program_loader #(
    .INST_W(16), .I_ADDR_W(12), .I_MEMORY_DEPTH(4096), .BYTE_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .reload(reload),
    .core_reset_n(core_reset_n),
    .busy(busy),
    .done(done),
    .load_error(load_error)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Record every instruction memory write mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_waddr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL in_ready_timeout: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Status vector order: busy, done, core_reset_n, load_error, in_ready.
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b want 00001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if ({bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_imem: got we=%b addr=%h data=%h want 0 0 0",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL post_reset_status: got %b want 00001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
  endtask

  task automatic test_good_frame();
    clear_writes();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_frame();
    send_byte(8'h34);
    checks++;
    if ({bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== {1'b1, 12'h000, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL good_write0: got we=%b addr=%h data=%h want 1 000 1234",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata);
    end
    send_byte(8'h56);
    send_byte(8'h78);
    checks++;
    if ({bus.imem_we, bus.imem_waddr, bus.imem_wdata} !== {1'b1, 12'h001, 16'h5678}) begin
      errors++;
      $display("[TB] FAIL good_write1: got we=%b addr=%h data=%h want 1 001 5678",
               bus.imem_we, bus.imem_waddr, bus.imem_wdata);
    end
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL good_before_csum: got %b want 10001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    send_byte(8'h14);
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL good_done: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL good_done_hold: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("[TB] FAIL good_write_count: got %0d want 2", wr_addr.size());
    end else if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !==
                 {12'h000, 16'h1234, 12'h001, 16'h5678}) begin
      errors++;
      $display("[TB] FAIL good_writes: got %h@%h %h@%h want 1234@000 5678@001",
               wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
  endtask

  task automatic test_reload();
    pulse_reload();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reload_status: got %b want 00001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    clear_writes();
    frame = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hC8};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL reload_done: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 1) begin
      errors++;
      $display("[TB] FAIL reload_write_count: got %0d want 1", wr_addr.size());
    end else if ({wr_addr[0], wr_data[0]} !== {12'h000, 16'hCAFE}) begin
      errors++;
      $display("[TB] FAIL reload_write: got %h@%h want cafe@000", wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_reload();
    clear_writes();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL badsum_error: got %b want 00010",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL badsum_idle: got %b want 00011",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("[TB] FAIL badsum_write_count: got %0d want 2", wr_addr.size());
    end
  endtask

  task automatic test_bad_length();
    clear_writes();
    send_byte(8'hA5);
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL sync_clears_error: got %b want 10001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL len_zero: got %b want 00010",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    frame = '{8'hA5, 8'h10, 8'h01};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL len_too_big: got %b want 00010",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("[TB] FAIL badlen_writes: got %0d want 0", wr_addr.size());
    end
  endtask

  task automatic test_garbage();
    clear_writes();
    frame = '{8'h00, 8'hFF, 8'h5A};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL garbage_ignored: got %b want 00011",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    frame = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL garbage_done: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 1) begin
      errors++;
      $display("[TB] FAIL garbage_write_count: got %0d want 1", wr_addr.size());
    end else if ({wr_addr[0], wr_data[0]} !== {12'h000, 16'hABCD}) begin
      errors++;
      $display("[TB] FAIL garbage_write: got %h@%h want abcd@000", wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_reset_midframe();
    pulse_reload();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL midframe_busy: got %b want 10001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready, bus.imem_we} !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got %b want 000010",
               {busy, done, core_reset_n, load_error, bus.in_ready, bus.imem_we});
    end
    reset_n = 1'b1;
    clear_writes();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midframe_stray_write: got %0d want 0", wr_addr.size());
    end
    frame = '{8'hA5, 8'h00, 8'h01, 8'h0F, 8'hF0, 8'hFF};
    send_frame();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL midframe_fresh_done: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 1) begin
      errors++;
      $display("[TB] FAIL midframe_write_count: got %0d want 1", wr_addr.size());
    end else if ({wr_addr[0], wr_data[0]} !== {12'h000, 16'h0FF0}) begin
      errors++;
      $display("[TB] FAIL midframe_write: got %h@%h want 0ff0@000", wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_abort();
    pulse_reload();
    clear_writes();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_frame();
    pulse_reload();
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL abort_status: got %b want 00001",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("[TB] FAIL abort_writes: got %0d want 0", wr_addr.size());
    end
  endtask

  task automatic test_max_depth();
    logic [7:0]  sum;
    logic [15:0] w;
    int          bad;
    sum = 8'h00;
    bad = 0;
    clear_writes();
    frame = '{8'hA5, 8'h10, 8'h00};
    send_frame();
    for (int i = 0; i < 4096; i++) begin
      w   = 16'(i * 37 + 11);
      sum = sum + w[15:8] + w[7:0];
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    send_byte(sum);
    checks++;
    if ({busy, done, core_reset_n, load_error, bus.in_ready} !== 5'b01100) begin
      errors++;
      $display("[TB] FAIL maxdepth_done: got %b want 01100",
               {busy, done, core_reset_n, load_error, bus.in_ready});
    end
    checks++;
    if (wr_addr.size() !== 4096) begin
      errors++;
      $display("[TB] FAIL maxdepth_write_count: got %0d want 4096", wr_addr.size());
    end else begin
      for (int i = 0; i < 4096; i++) begin
        w = 16'(i * 37 + 11);
        if (wr_addr[i] !== 12'(i) || wr_data[i] !== w) bad++;
      end
      if (bad != 0 || wr_addr[4095] !== 12'hFFF) begin
        errors++;
        $display("[TB] FAIL maxdepth_writes: got %0d bad words, last addr %h want 0 bad, fff",
                 bad, wr_addr[4095]);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_reload();
    test_bad_checksum();
    test_bad_length();
    test_garbage();
    test_reset_midframe();
    test_abort();
    test_max_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INST_W, default 16, instruction width; SHALL equal 2*BYTE_W.
REQ-002 Parameter I_ADDR_W, default 12, instruction memory address width.
REQ-003 Parameter I_MEMORY_DEPTH, default 1 << I_ADDR_W, maximum loadable instruction count.
REQ-004 Parameter BYTE_W, default 8, stream byte width.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  stream byte present.
REQ-008 in_data  input  BYTE_W  stream byte.
REQ-009 in_ready  output  1  loader accepts byte; a byte is transferred when in_valid && in_ready.
REQ-010 reload  input  1  single-cycle request to start a new load.
REQ-011 imem_we  output  1  instruction memory write strobe.
REQ-012 imem_waddr  output  I_ADDR_W  instruction memory write address.
REQ-013 imem_wdata  output  INST_W  instruction memory write data.
REQ-014 core_reset_n  output  1  active-low reset to turtle_cpu_core; low while not loaded.
REQ-015 busy  output  1  frame in progress (any state other than IDLE, DONE, ERROR).
REQ-016 done  output  1  valid program loaded.
REQ-017 load_error  output  1  last frame rejected.

Function
REQ-018 Frame format SHALL be: SYNC byte 0xA5, LEN_HI, LEN_LO (16-bit instruction count N), 2*N payload bytes (high byte first per instruction), one checksum byte.
REQ-019 States SHALL be IDLE, LEN_HI, LEN_LO, PAY_HI, PAY_LO, CHECKSUM, DONE, ERROR.
REQ-020 IDLE: accepted byte 0xA5 -> LEN_HI; any other accepted byte is discarded, state unchanged.
REQ-021 LEN_HI -> LEN_LO on accepted byte; LEN_LO -> PAY_HI on accepted byte if 1 <= N <= I_MEMORY_DEPTH, else -> ERROR.
REQ-022 PAY_HI latches high byte -> PAY_LO; PAY_LO completes the word -> PAY_HI, or -> CHECKSUM when it is the Nth word.
REQ-023 imem_we SHALL pulse high exactly one cycle, the cycle after the PAY_LO byte is accepted, with imem_waddr = word index (0 for first word) and imem_wdata = {high byte, low byte}.
REQ-024 Checksum SHALL be the 8-bit sum, modulo 2^BYTE_W, of all 2*N payload bytes; LEN and SYNC bytes excluded.
REQ-025 CHECKSUM: accepted byte equal to computed sum -> DONE; mismatch -> ERROR.
REQ-026 in_ready SHALL be 1 in IDLE, LEN_HI, LEN_LO, PAY_HI, PAY_LO, CHECKSUM and 0 in DONE and ERROR.
REQ-027 ERROR SHALL last exactly one cycle, then -> IDLE; load_error SHALL be set on entering ERROR and cleared when the next SYNC byte is accepted.
REQ-028 done and core_reset_n SHALL go high the cycle after the matching checksum byte is accepted and remain high while in DONE.
REQ-029 reload asserted in DONE SHALL -> IDLE, with done and core_reset_n low from the next cycle; reload in any other state SHALL abort the frame to IDLE without setting load_error.
REQ-030 Word address counter SHALL be I_ADDR_W+1 bits wide internally so N = I_MEMORY_DEPTH loads addresses 0..I_MEMORY_DEPTH-1 without wrapping.
REQ-031 Words written before an ERROR or abort are not rolled back; done stays low.

Reset
REQ-032 On reset_n low at a rising edge: state IDLE, imem_we 0, imem_waddr 0, imem_wdata 0, core_reset_n 0, busy 0, done 0, load_error 0, checksum and counters 0.
REQ-033 Reset mid-frame SHALL discard the frame; no imem_we pulse follows reset release.

Structure
REQ-034 Package turtle_loader_pkg SHALL hold the state enum and the SYNC_BYTE (0xA5) constant.
REQ-035 Block SHALL be a single module without sub-modules; it instantiates alongside turtle_cpu_subsystem, driving the core reset and instruction memory write port.

Verification
REQ-036 Frame A5 00 02 12 34 56 78 14 -> writes 0x1234@0, 0x5678@1; done=1, core_reset_n=1 one cycle after checksum byte.
REQ-037 Same frame with checksum 0x15 -> load_error=1, done=0, core_reset_n=0, return to IDLE after one cycle.
REQ-038 Frame A5 00 00 -> ERROR after LEN_LO; LEN 0x1001 with depth 4096 -> ERROR; no imem_we.
REQ-039 Garbage 00 FF 5A before A5 00 01 AB CD 78 -> garbage ignored, 0xABCD@0, done=1.
REQ-040 reset_n low after 3 payload bytes, then a fresh valid frame -> only the fresh frame's writes occur, done=1.
REQ-041 reload pulse in DONE -> core_reset_n=0 and done=0 next cycle, in_ready=1, second frame loads correctly.
